counter_updn_mod: RTL and testbench

//  Parametrised up/down modulo counter: successor to the basic load/increment counter.

---
 rtl/counter_updn_mod.sv | 122 ++++++++++++
 tb/tb_counter_updn_mod.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updn_mod.sv
// Up/down modulo counter with runtime limit, wrap/saturate modes, terminal-count, wrap pulse and sticky overflow.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN (adds prescale_i and an internal phase counter).
module counter_updn_mod #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      load_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic                      dir_i,
    input  logic                      sat_i,
    input  logic [DATA_WIDTH-1:0]     limit_i,
    input  logic                      clr_ovf_i,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
`endif
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic                      tc_o,
    output logic                      wrap_o,
    output logic                      ovf_o
);

    if (DATA_WIDTH < 1 || PRESCALE_WIDTH < 1) begin : g_bad_params
        $error("counter_updn_mod: DATA_WIDTH and PRESCALE_WIDTH must be at least 1");
    end

    localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wrap_q, wrap_d;
    logic                  ovf_q, ovf_d;
    logic                  step;
    logic                  hit;

`ifdef COUNTER_PRESCALE_EN
    localparam logic [PRESCALE_WIDTH-1:0] ONE_P = PRESCALE_WIDTH'(1);
    logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;
`endif

    always_comb begin
        data_d = data_q;
        wrap_d = 1'b0;
        ovf_d  = clr_ovf_i ? 1'b0 : ovf_q;
        step   = 1'b0;
        hit    = 1'b0;
`ifdef COUNTER_PRESCALE_EN
        psc_d  = psc_q;
`endif

        if (load_i) begin
            data_d = (data_i > limit_i) ? limit_i : data_i;
`ifdef COUNTER_PRESCALE_EN
            psc_d  = '0;
`endif
        end else if (en_i) begin
`ifdef COUNTER_PRESCALE_EN
            if (psc_q == prescale_i) begin
                step  = 1'b1;
                psc_d = '0;
            end else begin
                psc_d = psc_q + ONE_P;
            end
`else
            step = 1'b1;
`endif
        end

        if (step) begin
            if (dir_i) begin
                if (data_q < limit_i) begin
                    data_d = data_q + ONE_D;
                end else begin
                    hit    = 1'b1;
                    data_d = sat_i ? limit_i : '0;
                    wrap_d = ~sat_i;
                end
            end else begin
                // A count stranded above a freshly lowered limit snaps back silently.
                if (data_q > limit_i) begin
                    data_d = limit_i;
                end else if (data_q != '0) begin
                    data_d = data_q - ONE_D;
                end else begin
                    hit    = 1'b1;
                    data_d = sat_i ? '0 : limit_i;
                    wrap_d = ~sat_i;
                end
            end
        end

        // A boundary step in the same cycle as a clear leaves the flag set.
        if (hit) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef COUNTER_PRESCALE_EN
            psc_q  <= '0;
`endif
        end else begin
            data_q <= data_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
`ifdef COUNTER_PRESCALE_EN
            psc_q  <= psc_d;
`endif
        end
    end

    assign data_o = data_q;
    assign wrap_o = wrap_q;
    assign ovf_o  = ovf_q;
    assign tc_o   = dir_i ? (data_q >= limit_i) : (data_q == '0);

endmodule

// File: tb/tb_counter_updn_mod.sv
// Self-checking bench for counter_updn_mod: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural model (COUNTER_PRESCALE_EN aware).
module tb_counter_updn_mod;
    localparam int DW = 8;
    localparam int PW = 4;

    // Clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i     = 1'b1;
    logic          en_i      = 1'b0;
    logic          load_i    = 1'b0;
    logic          dir_i     = 1'b0;
    logic          sat_i     = 1'b0;
    logic          clr_ovf_i = 1'b0;
    logic [DW-1:0] data_i    = '0;
    logic [DW-1:0] limit_i   = '0;
`ifdef COUNTER_PRESCALE_EN
    logic [PW-1:0] prescale_i = '0;
`endif
    logic [DW-1:0] data_o;
    logic          tc_o;
    logic          wrap_o;
    logic          ovf_o;

    counter_updn_mod #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .load_i    (load_i),
        .data_i    (data_i),
        .dir_i     (dir_i),
        .sat_i     (sat_i),
        .limit_i   (limit_i),
        .clr_ovf_i (clr_ovf_i),
`ifdef COUNTER_PRESCALE_EN
        .prescale_i(prescale_i),
`endif
        .data_o    (data_o),
        .tc_o      (tc_o),
        .wrap_o    (wrap_o),
        .ovf_o     (ovf_o)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the counting rules
    int m_data = 0;
    int m_psc  = 0;
    bit m_wrap = 1'b0;
    bit m_ovf  = 1'b0;
    logic [DW+1:0] exp_q[$];

    always @(posedge clk) begin
        int lim;
        int q;
        bit hit;
        bit stp;
        lim    = int'(limit_i);
        q      = m_data;
        hit    = 1'b0;
        stp    = 1'b0;
        m_wrap = 1'b0;
        if (rst_i) begin
            m_data = 0;
            m_ovf  = 1'b0;
            m_psc  = 0;
        end else begin
            if (clr_ovf_i) m_ovf = 1'b0;
            if (load_i) begin
                m_data = (int'(data_i) > lim) ? lim : int'(data_i);
                m_psc  = 0;
            end else if (en_i) begin
                stp = 1'b1;
`ifdef COUNTER_PRESCALE_EN
                if (m_psc == int'(prescale_i)) begin
                    m_psc = 0;
                end else begin
                    m_psc = (m_psc + 1) % (1 << PW);
                    stp   = 1'b0;
                end
`endif
                if (stp) begin
                    if (dir_i) begin
                        if (q < lim) q = q + 1;
                        else begin
                            hit = 1'b1;
                            if (sat_i) q = lim;
                            else begin q = 0; m_wrap = 1'b1; end
                        end
                    end else begin
                        if (q > lim) q = lim;
                        else if (q > 0) q = q - 1;
                        else begin
                            hit = 1'b1;
                            if (sat_i) q = 0;
                            else begin q = lim; m_wrap = 1'b1; end
                        end
                    end
                    m_data = q;
                end
            end
            if (hit) m_ovf = 1'b1;
        end
        if (chk_en) exp_q.push_back({m_data[DW-1:0], m_wrap, m_ovf});
    end

    // Scoreboard compare: one expected entry per clock, checked on the falling edge
    always @(negedge clk) begin
        logic [DW+1:0] e;
        logic [DW-1:0] ed;
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                check("sb_entry_present", 32'd0, 32'd1);
            end else begin
                e  = exp_q.pop_front();
                ed = e[DW+1:2];
                check("sb_data_o", 32'(data_o), 32'(ed));
                check("sb_wrap_o", 32'(wrap_o), 32'(e[1]));
                check("sb_ovf_o",  32'(ovf_o),  32'(e[0]));
                check("sb_tc_o",   32'(tc_o),   32'(dir_i ? (ed >= limit_i) : (ed == '0)));
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input int d, input bit w, input bit o);
        check({name, "_data"},   32'(data_o), 32'(d));
        check({name, "_wrap"},   32'(wrap_o), 32'(w));
        check({name, "_ovf"},    32'(ovf_o),  32'(o));
        check({name, "_m_data"}, 32'(m_data), 32'(d));
        check({name, "_m_wrap"}, 32'(m_wrap), 32'(w));
        check({name, "_m_ovf"},  32'(m_ovf),  32'(o));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq1[7];
        int seq6[13];
        bit en6[13];
        seq1 = '{1, 2, 3, 4, 5, 0, 1};
        seq6 = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 3};
        en6  = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};

        // Reset state
        tick();
        expect_state("rst", 0, 1'b0, 1'b0);
        check("rst_tc_down", 32'(tc_o), 32'd1);
        chk_en = 1'b1;

        // Up count with wrap at limit 5
        rst_i = 1'b0; limit_i = 8'd5; dir_i = 1'b1; sat_i = 1'b0; en_i = 1'b1;
        #1;
        check("s1_tc_at0", 32'(tc_o), 32'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            expect_state("s1", seq1[i], i == 5, i >= 5);
        end

        // Saturate at 5, then clear interplay
        en_i = 1'b0; clr_ovf_i = 1'b1;
        tick();
        expect_state("s2_clr", 1, 1'b0, 1'b0);
        clr_ovf_i = 1'b0; sat_i = 1'b1; en_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_state("s2", (i + 2 > 5) ? 5 : i + 2, 1'b0, i >= 4);
        end
        check("s2_tc", 32'(tc_o), 32'd1);
        en_i = 1'b0; clr_ovf_i = 1'b1;
        tick();
        expect_state("s2_clr_idle", 5, 1'b0, 1'b0);
        en_i = 1'b1;
        tick();
        expect_state("s2_set_wins", 5, 1'b0, 1'b1);
        clr_ovf_i = 1'b0;

        // Down count with wrap at limit 9
        en_i = 1'b0; limit_i = 8'd9; load_i = 1'b1; data_i = 8'd1; dir_i = 1'b0; sat_i = 1'b0;
        tick();
        expect_state("s3_load", 1, 1'b0, 1'b1);
        load_i = 1'b0; en_i = 1'b1;
        tick();
        expect_state("s3_a", 0, 1'b0, 1'b1);
        check("s3_tc_zero", 32'(tc_o), 32'd1);
        tick();
        expect_state("s3_b", 9, 1'b1, 1'b1);
        tick();
        expect_state("s3_c", 8, 1'b0, 1'b1);

        // Load clamps and wins over step; lowered limit snaps count down
        en_i = 1'b0; clr_ovf_i = 1'b1;
        tick();
        expect_state("s4_clr", 8, 1'b0, 1'b0);
        clr_ovf_i = 1'b0; limit_i = 8'd100; load_i = 1'b1; data_i = 8'd200; en_i = 1'b1;
        tick();
        expect_state("s4_load", 100, 1'b0, 1'b0);
        load_i = 1'b0; limit_i = 8'd40;
        tick();
        expect_state("s4_snap", 40, 1'b0, 1'b0);

        // Mid-run reset
        dir_i = 1'b1; limit_i = 8'd10;
        tick();
        expect_state("s5_wrap", 0, 1'b1, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_state("s5_up", i, 1'b0, 1'b1);
        end
        rst_i = 1'b1;
        tick();
        expect_state("s5_rst", 0, 1'b0, 1'b0);
        rst_i = 1'b0;
        tick();
        expect_state("s5_r1", 1, 1'b0, 1'b0);
        tick();
        expect_state("s5_r2", 2, 1'b0, 1'b0);

        // Limit zero: every step is a boundary
        limit_i = 8'd0;
        tick();
        expect_state("lim0_up_a", 0, 1'b1, 1'b1);
        tick();
        expect_state("lim0_up_b", 0, 1'b1, 1'b1);
        dir_i = 1'b0;
        tick();
        expect_state("lim0_dn", 0, 1'b1, 1'b1);
        sat_i = 1'b1;
        tick();
        expect_state("lim0_sat", 0, 1'b0, 1'b1);

        // Full-range natural rollover
        sat_i = 1'b0; dir_i = 1'b1; limit_i = 8'd255; load_i = 1'b1; data_i = 8'd254;
        tick();
        expect_state("full_load", 254, 1'b0, 1'b1);
        load_i = 1'b0;
        tick();
        expect_state("full_255", 255, 1'b0, 1'b1);
        tick();
        expect_state("full_roll", 0, 1'b1, 1'b1);

`ifdef COUNTER_PRESCALE_EN
        // Prescaled stepping with an enable gap mid-phase
        rst_i = 1'b1;
        tick();
        expect_state("s6_rst", 0, 1'b0, 1'b0);
        rst_i = 1'b0; prescale_i = 4'd2; limit_i = 8'd255; dir_i = 1'b1; sat_i = 1'b0;
        for (int i = 0; i < 13; i++) begin
            en_i = en6[i];
            tick();
            expect_state("s6", seq6[i], 1'b0, 1'b0);
        end
`endif

        // Randomized phase
        for (int n = 0; n < 2000; n++) begin
            rst_i     = ($urandom_range(0, 99) == 0);
            load_i    = ($urandom_range(0, 19) == 0);
            en_i      = ($urandom_range(0, 3) != 0);
            dir_i     = ($urandom_range(0, 7) != 0) ? dir_i : ~dir_i;
            sat_i     = ($urandom_range(0, 15) != 0) ? sat_i : ~sat_i;
            clr_ovf_i = ($urandom_range(0, 15) == 0);
            data_i    = DW'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       limit_i = '0;
                    1:       limit_i = DW'($urandom_range(1, 7));
                    2:       limit_i = 8'd255;
                    default: limit_i = DW'($urandom_range(0, 255));
                endcase
            end
`ifdef COUNTER_PRESCALE_EN
            if ($urandom_range(0, 31) == 0) prescale_i = PW'($urandom_range(0, 3));
`endif
            tick();
        end

        rst_i = 1'b0; load_i = 1'b0; en_i = 1'b0; clr_ovf_i = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
